rf_windowed_spill: RTL and testbench

//  Parametrised windowed register file with an autonomous spill/fill engine. It provides globals plus

---
 rtl/rf_win_pkg.sv | 33 +++
 rtl/rf_win_addr_map.sv | 41 ++++
 rtl/rf_windowed_spill.sv | 219 +++++++++++++++++++++
 tb/tb_rf_windowed_spill.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_win_pkg.sv
// rf_win_pkg
//   Shared types and helpers for the windowed register file.
//   state_t  : spill/fill engine states
//   region_t : which part of the logical window an address falls into
//   classify : logical register number -> region
//   win_phys : (window, offset within window) -> physical register index
package rf_win_pkg;

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  typedef enum logic [2:0] {GLB, IN, LOC, OUT, BAD} region_t;

  function automatic region_t classify(input int unsigned r,
                                       input int unsigned nglb,
                                       input int unsigned nio,
                                       input int unsigned nloc);
    if (r < nglb)                       return GLB;
    else if (r < nglb + nio)            return IN;
    else if (r < nglb + nio + nloc)     return LOC;
    else if (r < nglb + 2*nio + nloc)   return OUT;
    else                                return BAD;
  endfunction

  // Windowed registers form a ring of nwin*p entries placed after the globals.
  function automatic int unsigned win_phys(input int unsigned w,
                                           input int unsigned s,
                                           input int unsigned nglb,
                                           input int unsigned p,
                                           input int unsigned nwin);
    return nglb + ((w * p + s) % (nwin * p));
  endfunction

endpackage

// File: rtl/rf_win_addr_map.sv
// rf_win_addr_map
//   Combinational logical->physical register address mapper.
//   addr  : logical register number (globals, IN, LOCAL, OUT)
//   win   : window the address is interpreted in
//   phys  : physical register index
//   valid : low when addr lies beyond the logical window
module rf_win_addr_map
  import rf_win_pkg::*;
#(
  parameter int unsigned NGLB = 8,
  parameter int unsigned NIO  = 8,
  parameter int unsigned NLOC = 8,
  parameter int unsigned NWIN = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned CW   = 2,
  parameter int unsigned PW   = 7
) (
  input  logic [AW-1:0] addr,
  input  logic [CW-1:0] win,
  output logic [PW-1:0] phys,
  output logic          valid
);

  localparam int unsigned P = NIO + NLOC;

  region_t region;

  // IN, LOCAL and OUT are all offset (addr-NGLB) from the window base: OUT k
  // sits at offset P+k, which is IN k of the next window in the ring.
  always_comb begin
    region = classify(32'(addr), NGLB, NIO, NLOC);
    phys   = '0;
    valid  = 1'b1;
    case (region)
      GLB:          phys = PW'(addr);
      IN, LOC, OUT: phys = PW'(win_phys(32'(win), 32'(addr) - NGLB, NGLB, P, NWIN));
      default:      valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/rf_windowed_spill.sv
// rf_windowed_spill
//   Windowed register file (globals + overlapping IN/LOCAL/OUT windows) with
//   two registered read ports, one write port and an engine that spills the
//   oldest window to an external stack on CALL overflow and fills it back on
//   SIGRETURN underflow.
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   enable                : gates rd1/rd2/wr/call/sigreturn
//   rd1, rd2, wr          : read/write strobes
//   call, sigreturn       : window advance / return
//   add_wr, add_rd1/2     : logical addresses
//   datain                : write data
//   mem_bus_read          : fill data from the memory stack
//   mem_ready             : one word moves this cycle
//   out1, out2            : registered read data
//   mem_bus               : spill data to the memory stack
//   fill, spill, busy     : engine status / transfer requests
//   cwp                   : current window pointer
// Configuration
//   RF_WIN_BYPASS_EN : when defined, a read hitting the same physical register
//   as a write accepted in the same cycle returns datain.
module rf_windowed_spill
  import rf_win_pkg::*;
#(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned NGLB   = 8,
  parameter int unsigned NIO    = 8,
  parameter int unsigned NLOC   = 8,
  parameter int unsigned NWIN   = 4,
  parameter int unsigned SPW    = 8,
  localparam int unsigned WSZ   = NGLB + 2*NIO + NLOC,
  localparam int unsigned AW    = $clog2(WSZ),
  localparam int unsigned CW    = $clog2(NWIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rd1,
  input  logic              rd2,
  input  logic              wr,
  input  logic              call,
  input  logic              sigreturn,
  input  logic [AW-1:0]     add_wr,
  input  logic [AW-1:0]     add_rd1,
  input  logic [AW-1:0]     add_rd2,
  input  logic [DWIDTH-1:0] datain,
  input  logic [DWIDTH-1:0] mem_bus_read,
  input  logic              mem_ready,
  output logic [DWIDTH-1:0] out1,
  output logic [DWIDTH-1:0] out2,
  output logic [DWIDTH-1:0] mem_bus,
  output logic              fill,
  output logic              spill,
  output logic              busy,
  output logic [CW-1:0]     cwp
);

  localparam int unsigned P     = NIO + NLOC;
  localparam int unsigned NPHYS = NGLB + NWIN * P;
  localparam int unsigned PW    = $clog2(NPHYS);
  localparam int unsigned CNTW  = $clog2(P);
  localparam int unsigned RW    = $clog2(NWIN) + 1;

  logic [DWIDTH-1:0] mem [NPHYS];

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [CW-1:0]     swp;
  logic [RW-1:0]     resident;
  logic [SPW-1:0]    spilled;

  logic [PW-1:0]     wr_phys, rd1_phys, rd2_phys;
  logic              wr_valid, rd1_valid, rd2_valid;
  logic [DWIDTH-1:0] rd1_data, rd2_data;
  logic              idle, wr_accept, call_req, ret_req;
  logic [CW-1:0]     fill_win;
  logic [PW-1:0]     spill_first_phys, spill_next_phys, fill_phys;

  function automatic logic [CW-1:0] win_inc(input logic [CW-1:0] w);
    return (w == CW'(NWIN - 1)) ? '0 : w + CW'(1);
  endfunction

  function automatic logic [CW-1:0] win_dec(input logic [CW-1:0] w);
    return (w == '0) ? CW'(NWIN - 1) : w - CW'(1);
  endfunction

  rf_win_addr_map #(.NGLB(NGLB), .NIO(NIO), .NLOC(NLOC), .NWIN(NWIN),
                    .AW(AW), .CW(CW), .PW(PW))
    u_map_wr  (.addr(add_wr),  .win(cwp), .phys(wr_phys),  .valid(wr_valid));

  rf_win_addr_map #(.NGLB(NGLB), .NIO(NIO), .NLOC(NLOC), .NWIN(NWIN),
                    .AW(AW), .CW(CW), .PW(PW))
    u_map_rd1 (.addr(add_rd1), .win(cwp), .phys(rd1_phys), .valid(rd1_valid));

  rf_win_addr_map #(.NGLB(NGLB), .NIO(NIO), .NLOC(NLOC), .NWIN(NWIN),
                    .AW(AW), .CW(CW), .PW(PW))
    u_map_rd2 (.addr(add_rd2), .win(cwp), .phys(rd2_phys), .valid(rd2_valid));

  assign idle      = (state == IDLE);
  assign wr_accept = enable && idle && wr && wr_valid;
  // CALL and SIGRETURN together cancel out.
  assign call_req  = enable && idle && call && !sigreturn;
  assign ret_req   = enable && idle && sigreturn && !call;

  // Spill walks IN0..LOCn forward; fill walks the previous window backwards
  // so the stack behaves as LIFO.
  assign fill_win         = win_dec(swp);
  assign spill_first_phys = PW'(win_phys(32'(swp), 0, NGLB, P, NWIN));
  assign spill_next_phys  = PW'(win_phys(32'(swp), 32'(cnt) + 32'd1, NGLB, P, NWIN));
  assign fill_phys        = PW'(win_phys(32'(fill_win), P - 1 - 32'(cnt), NGLB, P, NWIN));

  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    if (rd1_valid) rd1_data = mem[rd1_phys];
    if (rd2_valid) rd2_data = mem[rd2_phys];
`ifdef RF_WIN_BYPASS_EN
    if (wr_accept && rd1_valid && (rd1_phys == wr_phys)) rd1_data = datain;
    if (wr_accept && rd2_valid && (rd2_phys == wr_phys)) rd2_data = datain;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NPHYS); i++) mem[i] <= '0;
    end else begin
      if (wr_accept) mem[wr_phys] <= datain;
      if ((state == FILL) && mem_ready) mem[fill_phys] <= mem_bus_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1 <= '0;
      out2 <= '0;
    end else if (enable && idle) begin
      if (rd1) out1 <= rd1_data;
      if (rd2) out2 <= rd2_data;
    end
  end

  // Window bookkeeping and spill/fill engine. mem_bus is preloaded with the
  // next word so it is valid for the whole cycle the word is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cwp      <= '0;
      swp      <= '0;
      resident <= RW'(1);
      spilled  <= '0;
      spill    <= 1'b0;
      fill     <= 1'b0;
      busy     <= 1'b0;
      mem_bus  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (call_req) begin
            if (resident < RW'(NWIN - 1)) begin
              cwp      <= win_inc(cwp);
              resident <= resident + RW'(1);
            end else if (spilled != '1) begin
              state   <= SPILL;
              cnt     <= '0;
              spill   <= 1'b1;
              busy    <= 1'b1;
              mem_bus <= mem[spill_first_phys];
            end
          end else if (ret_req) begin
            if (resident > RW'(1)) begin
              cwp      <= win_dec(cwp);
              resident <= resident - RW'(1);
            end else if (spilled != '0) begin
              state <= FILL;
              cnt   <= '0;
              fill  <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        SPILL: begin
          if (mem_ready) begin
            if (cnt == CNTW'(P - 1)) begin
              state   <= IDLE;
              cnt     <= '0;
              spill   <= 1'b0;
              busy    <= 1'b0;
              mem_bus <= '0;
              swp     <= win_inc(swp);
              cwp     <= win_inc(cwp);
              spilled <= spilled + SPW'(1);
            end else begin
              cnt     <= cnt + CNTW'(1);
              mem_bus <= mem[spill_next_phys];
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            if (cnt == CNTW'(P - 1)) begin
              state   <= IDLE;
              cnt     <= '0;
              fill    <= 1'b0;
              busy    <= 1'b0;
              swp     <= win_dec(swp);
              cwp     <= win_dec(cwp);
              spilled <= spilled - SPW'(1);
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_windowed_spill.sv
// tb_rf_windowed_spill
//   Directed bench for rf_windowed_spill with default parameters
//   (NWIN=4, NGLB=8, NIO=8, NLOC=8, DWIDTH=64).
module tb_rf_windowed_spill;

  logic        clk = 1'b0;
  logic        rst_n, enable, rd1, rd2, wr, call, sigreturn, mem_ready;
  logic [4:0]  add_wr, add_rd1, add_rd2;
  logic [63:0] datain, mem_bus_read;
  logic [63:0] out1, out2, mem_bus;
  logic        fill, spill, busy;
  logic [1:0]  cwp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_windowed_spill dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .rd1(rd1), .rd2(rd2), .wr(wr), .call(call), .sigreturn(sigreturn),
    .add_wr(add_wr), .add_rd1(add_rd1), .add_rd2(add_rd2),
    .datain(datain), .mem_bus_read(mem_bus_read), .mem_ready(mem_ready),
    .out1(out1), .out2(out2), .mem_bus(mem_bus),
    .fill(fill), .spill(spill), .busy(busy), .cwp(cwp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b1; rd1 = 1'b0; rd2 = 1'b0; wr = 1'b0;
    call = 1'b0; sigreturn = 1'b0; mem_ready = 1'b1;
    add_wr = '0; add_rd1 = '0; add_rd2 = '0; datain = '0; mem_bus_read = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    wr = 1'b1; add_wr = a; datain = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic do_read1(input logic [4:0] a);
    rd1 = 1'b1; add_rd1 = a;
    tick();
    rd1 = 1'b0;
  endtask

  task automatic do_read2(input logic [4:0] a);
    rd2 = 1'b1; add_rd2 = a;
    tick();
    rd2 = 1'b0;
  endtask

  task automatic do_call();
    call = 1'b1;
    tick();
    call = 1'b0;
  endtask

  task automatic do_ret();
    sigreturn = 1'b1;
    tick();
    sigreturn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; rd1 = 1'b0; rd2 = 1'b0; wr = 1'b0;
    call = 1'b0; sigreturn = 1'b0; mem_ready = 1'b1;
    add_wr = '0; add_rd1 = '0; add_rd2 = '0; datain = '0; mem_bus_read = '0;
    tick(); tick();
    checks++; if (out1 !== 64'h0) begin failures++; $display("[TB] FAIL reset_out1 got=%h exp=0", out1); end
    checks++; if (out2 !== 64'h0) begin failures++; $display("[TB] FAIL reset_out2 got=%h exp=0", out2); end
    checks++; if (mem_bus !== 64'h0) begin failures++; $display("[TB] FAIL reset_mem_bus got=%h exp=0", mem_bus); end
    checks++; if ({spill, fill, busy} !== 3'b000) begin failures++; $display("[TB] FAIL reset_strobes got=%b exp=000", {spill, fill, busy}); end
    rst_n = 1'b1;
    tick();
    do_read1(5'd3);
    checks++; if (out1 !== 64'h0) begin failures++; $display("[TB] FAIL reset_read_g3 got=%h exp=0", out1); end
    checks++; if (cwp !== 2'd0) begin failures++; $display("[TB] FAIL reset_cwp got=%0d exp=0", cwp); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write_call();
    logic [63:0] exp;
    apply_reset();
    do_write(5'd24, 64'hAA);
    do_call();
    checks++; if (cwp !== 2'd1) begin failures++; $display("[TB] FAIL call_cwp got=%0d exp=1", cwp); end
    do_read1(5'd8);
    checks++; if (out1 !== 64'hAA) begin failures++; $display("[TB] FAIL out_to_in got=%h exp=aa", out1); end
    do_write(5'd3, 64'h33);
    do_read2(5'd3);
    checks++; if (out2 !== 64'h33) begin failures++; $display("[TB] FAIL global_rd2 got=%h exp=33", out2); end
    // simultaneous write and read of the same register
    wr = 1'b1; add_wr = 5'd3; datain = 64'h55; rd1 = 1'b1; add_rd1 = 5'd3;
    tick();
    wr = 1'b0; rd1 = 1'b0;
`ifdef RF_WIN_BYPASS_EN
    exp = 64'h55;
`else
    exp = 64'h33;
`endif
    checks++; if (out1 !== exp) begin failures++; $display("[TB] FAIL same_cycle_rw got=%h exp=%h", out1, exp); end
    do_read1(5'd3);
    checks++; if (out1 !== 64'h55) begin failures++; $display("[TB] FAIL after_write got=%h exp=55", out1); end
    enable = 1'b0;
    do_write(5'd4, 64'h99);
    enable = 1'b1;
    do_read1(5'd4);
    checks++; if (out1 !== 64'h0) begin failures++; $display("[TB] FAIL enable_low_wr got=%h exp=0", out1); end
    // write together with CALL lands in the old window's OUT
    wr = 1'b1; add_wr = 5'd24; datain = 64'h77; call = 1'b1;
    tick();
    wr = 1'b0; call = 1'b0;
    checks++; if (cwp !== 2'd2) begin failures++; $display("[TB] FAIL wr_call_cwp got=%0d exp=2", cwp); end
    do_read1(5'd8);
    checks++; if (out1 !== 64'h77) begin failures++; $display("[TB] FAIL wr_call_old_cwp got=%h exp=77", out1); end
    call = 1'b1; sigreturn = 1'b1;
    tick();
    call = 1'b0; sigreturn = 1'b0;
    checks++; if ({cwp, busy} !== 3'b100) begin failures++; $display("[TB] FAIL call_ret_noop got=%b exp=100", {cwp, busy}); end
    do_ret();
    checks++; if (cwp !== 2'd1) begin failures++; $display("[TB] FAIL ret_cwp got=%0d exp=1", cwp); end
    do_read1(5'd8);
    checks++; if (out1 !== 64'hAA) begin failures++; $display("[TB] FAIL ret_reread got=%h exp=aa", out1); end
  endtask

  task automatic test_spill_fill();
    int nw;
    int cyc;
    apply_reset();
    for (int s = 0; s < 16; s++) do_write(5'(8 + s), 64'hA000 + 64'(s));
    do_call();
    do_call();
    checks++; if (cwp !== 2'd2) begin failures++; $display("[TB] FAIL pre_spill_cwp got=%0d exp=2", cwp); end
    do_call();
    checks++; if ({spill, busy} !== 2'b11) begin failures++; $display("[TB] FAIL spill_start got=%b exp=11", {spill, busy}); end
    checks++; if (cwp !== 2'd2) begin failures++; $display("[TB] FAIL spill_cwp_hold got=%0d exp=2", cwp); end
    nw = 0; cyc = 0;
    while (spill === 1'b1 && cyc < 64) begin
      checks++; if (mem_bus !== 64'hA000 + 64'(nw)) begin failures++; $display("[TB] FAIL spill_word%0d got=%h exp=%h", nw, mem_bus, 64'hA000 + 64'(nw)); end
      nw++; cyc++;
      tick();
    end
    checks++; if (nw !== 16) begin failures++; $display("[TB] FAIL spill_count got=%0d exp=16", nw); end
    checks++; if ({cwp, busy, mem_bus == 64'h0} !== 4'b1101) begin failures++; $display("[TB] FAIL spill_end got=%b exp=1101", {cwp, busy, mem_bus == 64'h0}); end
    // window 3's OUT wraps onto window 0's IN: clobber it before the fill
    for (int k = 0; k < 8; k++) do_write(5'(24 + k), 64'hDEAD0000 + 64'(k));
    do_read1(5'd24);
    checks++; if (out1 !== 64'hDEAD0000) begin failures++; $display("[TB] FAIL wrap_out got=%h exp=dead0000", out1); end
    do_ret();
    checks++; if ({cwp, busy} !== 3'b100) begin failures++; $display("[TB] FAIL ret1 got=%b exp=100", {cwp, busy}); end
    do_ret();
    checks++; if ({cwp, busy} !== 3'b010) begin failures++; $display("[TB] FAIL ret2 got=%b exp=010", {cwp, busy}); end
    do_ret();
    checks++; if ({fill, busy} !== 2'b11) begin failures++; $display("[TB] FAIL fill_start got=%b exp=11", {fill, busy}); end
    nw = 0; cyc = 0;
    while (fill === 1'b1 && cyc < 64) begin
      mem_bus_read = 64'hA000 + 64'(15 - nw);
      nw++; cyc++;
      tick();
    end
    checks++; if (nw !== 16) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=16", nw); end
    checks++; if ({cwp, busy} !== 3'b000) begin failures++; $display("[TB] FAIL fill_end got=%b exp=000", {cwp, busy}); end
    for (int s = 0; s < 16; s++) begin
      do_read1(5'(8 + s));
      checks++; if (out1 !== 64'hA000 + 64'(s)) begin failures++; $display("[TB] FAIL refill_r%0d got=%h exp=%h", 8 + s, out1, 64'hA000 + 64'(s)); end
    end
    do_ret();
    checks++; if ({cwp, busy, fill} !== 4'b0000) begin failures++; $display("[TB] FAIL underflow_ignored got=%b exp=0000", {cwp, busy, fill}); end
  endtask

  task automatic test_spill_stall();
    int nw;
    int cyc;
    int stalls;
    apply_reset();
    for (int s = 0; s < 16; s++) do_write(5'(8 + s), 64'hB000 + 64'(s));
    do_call(); do_call(); do_call();
    nw = 0; cyc = 0; stalls = 0;
    while (spill === 1'b1 && cyc < 64) begin
      if (nw == 5 && stalls < 5) begin
        mem_ready = 1'b0;
        checks++; if ({busy, mem_bus} !== {1'b1, 64'hB005}) begin failures++; $display("[TB] FAIL stall_hold got=%b/%h exp=1/b005", busy, mem_bus); end
        stalls++;
      end else begin
        mem_ready = 1'b1;
        checks++; if (mem_bus !== 64'hB000 + 64'(nw)) begin failures++; $display("[TB] FAIL stall_word%0d got=%h exp=%h", nw, mem_bus, 64'hB000 + 64'(nw)); end
        nw++;
      end
      cyc++;
      tick();
    end
    mem_ready = 1'b1;
    checks++; if (nw !== 16) begin failures++; $display("[TB] FAIL stall_words got=%0d exp=16", nw); end
    checks++; if (cyc !== 21) begin failures++; $display("[TB] FAIL stall_cycles got=%0d exp=21", cyc); end
    checks++; if ({cwp, busy} !== 3'b110) begin failures++; $display("[TB] FAIL stall_end got=%b exp=110", {cwp, busy}); end
  endtask

  task automatic test_reset_mid_spill();
    apply_reset();
    for (int s = 0; s < 16; s++) do_write(5'(8 + s), 64'hC000 + 64'(s));
    do_read1(5'd8);
    checks++; if (out1 !== 64'hC000) begin failures++; $display("[TB] FAIL pre_abort_read got=%h exp=c000", out1); end
    do_call(); do_call(); do_call();
    tick(); tick(); tick(); tick();
    checks++; if (mem_bus !== 64'hC004) begin failures++; $display("[TB] FAIL mid_spill_word got=%h exp=c004", mem_bus); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out1, mem_bus} !== 128'h0) begin failures++; $display("[TB] FAIL abort_data got=%h/%h exp=0/0", out1, mem_bus); end
    checks++; if ({cwp, spill, busy} !== 4'b0000) begin failures++; $display("[TB] FAIL abort_ctrl got=%b exp=0000", {cwp, spill, busy}); end
    tick();
    rst_n = 1'b1;
    tick();
    do_read1(5'd8);
    checks++; if (out1 !== 64'h0) begin failures++; $display("[TB] FAIL abort_cleared got=%h exp=0", out1); end
  endtask

  initial begin
    test_reset();
    test_write_call();
    test_spill_fill();
    test_spill_stall();
    test_reset_mid_spill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
